// File: rtl/l16_mod_sub_pipe.sv
// Three-stage pipelined modulo (2^16-1) subtractor: diff = a + ~b with end-around carry,
// using a cyclic Ling prefix (H/Pr) split across S1..S3 and a global-stall valid/ready pipe.
module l16_mod_sub_pipe #(
    parameter bit NORM_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        zero
);

    // Left-rotate: bit i takes bit (i-k) mod 16.
    function automatic logic [15:0] rotl(input logic [15:0] v, input int unsigned k);
        logic [31:0] w;
        w = {v, v} << k;
        return w[31:16];
    endfunction

    logic        adv;
    logic        v1, v2, v3;

    logic [15:0] bn, g, p, x, h1, pr1;
    logic [15:0] s1_h, s1_pr, s1_p, s1_x;

    logic [15:0] h2, pr2, h3, pr3;
    logic [15:0] s2_h, s2_pr, s2_p, s2_x;

    logic [15:0] h4, hc, raw;
    logic        zero_raw;
    logic [15:0] diff_next;
    logic [15:0] s3_diff;
    logic        s3_zero;

    assign adv      = ~v3 | out_ready;
    assign in_ready = adv;

    always_comb begin
        bn  = ~b;
        g   = a & bn;
        p   = a | bn;
        x   = a ^ bn;
        h1  = g | rotl(g, 1);
        pr1 = p & rotl(p, 1);
    end

    always_comb begin
        h2  = s1_h | (rotl(s1_pr, 1) & rotl(s1_h, 2));
        pr2 = s1_pr & rotl(s1_pr, 2);
        h3  = h2 | (rotl(pr2, 1) & rotl(h2, 4));
        pr3 = pr2 & rotl(pr2, 4);
    end

    // The final span closes the 16-bit ring, so the carry into bit i is p[i-1] & H4[i-1].
    always_comb begin
        h4        = s2_h | (rotl(s2_pr, 1) & rotl(s2_h, 8));
        hc        = rotl(h4, 1);
        raw       = (~hc & s2_x) | (hc & (s2_x ^ rotl(s2_p, 1)));
        zero_raw  = (raw == 16'h0000) || (raw == 16'hFFFF);
        diff_next = (NORM_ZERO && (raw == 16'hFFFF)) ? 16'h0000 : raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s3_diff <= 16'h0000;
            s3_zero <= 1'b0;
        end else if (adv) begin
            v1      <= in_valid;
            v2      <= v1;
            v3      <= v2;
            s3_diff <= diff_next;
            s3_zero <= zero_raw;
        end
    end

    // Contents of invalid S1/S2 slots are don't-care, so these carry no reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_h  <= h1;
            s1_pr <= pr1;
            s1_p  <= p;
            s1_x  <= x;
            s2_h  <= h3;
            s2_pr <= pr3;
            s2_p  <= s1_p;
            s2_x  <= s1_x;
        end
    end

    assign out_valid = v3;
    assign diff      = s3_diff;
    assign zero      = s3_zero;

endmodule

// File: tb/tb_l16_mod_sub_pipe.sv
// Bench for l16_mod_sub_pipe: directed steps plus a random stream, with a scoreboard
// comparing both a normalizing (NORM_ZERO=1) and a raw (NORM_ZERO=0) instance.
module tb_l16_mod_sub_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a, b;
    logic        out_ready;
    logic        in_ready, out_valid, zero;
    logic [15:0] diff;
    logic        in_ready_r, out_valid_r, zero_r;
    logic [15:0] diff_r;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    typedef struct packed {
        logic [15:0] norm;
        logic [15:0] raw;
        logic        z;
    } exp_t;

    exp_t sb[$];
    logic prev_stall = 1'b0;

    l16_mod_sub_pipe #(.NORM_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .zero(zero)
    );

    l16_mod_sub_pipe #(.NORM_ZERO(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .a(a), .b(b),
        .out_valid(out_valid_r), .out_ready(out_ready), .diff(diff_r), .zero(zero_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: residue difference, and the all-ones-zero form produced by end-around carry.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb);
        exp_t        e;
        logic [16:0] s;
        int unsigned m;
        s      = {1'b0, ma} + {1'b0, ~mb};
        e.raw  = s[15:0] + {15'b0, s[16]};
        m      = (32'(ma) + 32'd65535 - 32'(mb)) % 32'd65535;
        e.norm = m[15:0];
        e.z    = (m == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold_valid", {31'b0, out_valid}, 32'd1);
            if (out_valid) begin
                chk("raw_valid", {31'b0, out_valid_r}, 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    chk("sb_diff", {16'b0, diff}, {16'b0, e.norm});
                    chk("sb_zero", {31'b0, zero}, {31'b0, e.z});
                    chk("sb_raw_diff", {16'b0, diff_r}, {16'b0, e.raw});
                    chk("sb_raw_zero", {31'b0, zero_r}, {31'b0, e.z});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                chk("raw_in_ready", {31'b0, in_ready_r}, 32'd1);
                sb.push_back(model(a, b));
            end
            prev_stall = out_valid && !out_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [15:0] ta, input logic [15:0] tb,
                           input logic [15:0] en, input logic [15:0] er, input logic ez);
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        @(negedge clk);
        chk("one_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("latency_early", {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        chk("latency_valid", {31'b0, out_valid}, 32'd1);
        chk("one_diff", {16'b0, diff}, {16'b0, en});
        chk("one_zero", {31'b0, zero}, {31'b0, ez});
        chk("one_raw_diff", {16'b0, diff_r}, {16'b0, er});
        step();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    initial begin
        int          start_out;
        int          acc;
        int          cyc;
        logic        taken;
        logic [15:0] ops_a [4];
        logic [15:0] ops_b [4];
        ops_a = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        ops_b = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_diff", {16'b0, diff}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        run_one(16'h0005, 16'h0003, 16'h0002, 16'h0002, 1'b0);
        run_one(16'h0003, 16'h0005, 16'hFFFD, 16'hFFFD, 1'b0);
        run_one(16'h0000, 16'h0001, 16'hFFFE, 16'hFFFE, 1'b0);
        run_one(16'h1234, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
        run_one(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
        run_one(16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);

        // Back-pressure: three fill the pipe, the fourth waits.
        step();
        out_ready = 1'b0;
        start_out = n_out;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            in_valid = 1'b1;
            a        = ops_a[i];
            b        = ops_b[i];
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("bp_stall_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_hold_diff", {16'b0, diff}, 32'h000F);
        end
        step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        drain("bp_drain", 20);
        chk("bp_count", n_out - start_out, 32'd4);

        // Reset with two operands in flight.
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h0100;
        b         = 16'h0001;
        step();
        a = 16'h0200;
        b = 16'h0002;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_diff", {16'b0, diff}, 32'd0);
        chk("mid_rst_zero", {31'b0, zero}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk("no_stale", {31'b0, out_valid}, 32'd0);
        end

        // Random stream with random stalls on both sides.
        acc = 0;
        cyc = 0;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (acc < 10000 && cyc < 60000) begin
            @(negedge clk);
            taken = in_valid && in_ready;
            if (taken) acc++;
            step();
            cyc++;
            if (!in_valid || taken) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a        = 16'($urandom);
                b        = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("rand_accepts", (acc >= 10000) ? 32'd1 : 32'd0, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
